// File: rtl/isram_loader_pkg.sv
// Shared types and AHB-Lite constants for the instruction SRAM loader.
package isram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } loader_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/ahb_isram_loader_if.sv
// Byte stream input plus AHB-Lite initiator signals of the SRAM loader.
interface ahb_isram_loader_if #(
  parameter int unsigned AW = 16
);

  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;

  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic          HMASTLOCK;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    input  s_data, s_valid, HREADY, HRESP,
    output s_ready, HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA
  );

  modport slave (
    output s_data, s_valid, HREADY, HRESP,
    input  s_ready, HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA
  );

endinterface

// File: rtl/byte_word_packer.sv
// Little-endian 8-to-32 packer: first byte lands in [7:0], fourth in [31:24].
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_take,
  output logic [31:0] o_word,
  output logic [1:0]  o_count,
  output logic        o_word_valid
);

  logic [31:0] r_word;
  logic [1:0]  r_count;
  logic        r_word_valid;

  // Shifting in from the top leaves byte 0 at the bottom after four bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= 32'h0;
      r_count      <= 2'd0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_word       <= 32'h0;
      r_count      <= 2'd0;
      r_word_valid <= 1'b0;
    end else begin
      if (i_take) begin
        r_word_valid <= 1'b0;
      end
      if (i_byte_valid) begin
        r_word  <= {i_byte, r_word[31:8]};
        r_count <= r_count + 2'd1;
        if (r_count == 2'd3) begin
          r_word_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_count      = r_count;
  assign o_word_valid = r_word_valid;

endmodule

// File: rtl/ahb_isram_loader.sv
// AHB-Lite initiator writing a byte stream into instruction SRAM, one single word per beat.
// Optional running checksum of OKAY words when ISRAM_LOADER_CHECKSUM_EN is defined.
module ahb_isram_loader
  import isram_loader_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned LEN_W = 14
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LEN_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
`ifdef ISRAM_LOADER_CHECKSUM_EN
  output logic [31:0]      checksum,
`endif
  ahb_isram_loader_if.master bus
);

  loader_state_e    r_state, w_state_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
  logic             r_error, w_error_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy;
  logic             r_s_ready;
  logic [1:0]       r_htrans;
  logic             r_hwrite;
  logic [31:0]      r_hwdata, w_hwdata_nxt;
`ifdef ISRAM_LOADER_CHECKSUM_EN
  logic [31:0]      r_checksum, w_checksum_nxt;
`endif

  logic             w_clear;
  logic             w_take;
  logic             w_byte_fire;
  logic [31:0]      w_pack_word;
  logic [1:0]       w_pack_count;
  logic             w_word_valid;

  assign w_byte_fire = bus.s_valid && r_s_ready;

  byte_word_packer u_packer (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .i_clear      (w_clear),
    .i_byte_valid (w_byte_fire),
    .i_byte       (bus.s_data),
    .i_take       (w_take),
    .o_word       (w_pack_word),
    .o_count      (w_pack_count),
    .o_word_valid (w_word_valid)
  );

  // Next-state and next-register values; registered below so every output is a flop.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_error_nxt     = r_error;
    w_hwdata_nxt    = r_hwdata;
    w_done_nxt      = 1'b0;
    w_clear         = 1'b0;
    w_take          = 1'b0;
`ifdef ISRAM_LOADER_CHECKSUM_EN
    w_checksum_nxt  = r_checksum;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear         = 1'b1;
          w_addr_nxt      = base_addr & ~AW'(3);
          w_remaining_nxt = word_count;
          w_error_nxt     = 1'b0;
`ifdef ISRAM_LOADER_CHECKSUM_EN
          w_checksum_nxt  = 32'h0;
`endif
          if (word_count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (w_byte_fire && (w_pack_count == 2'd3)) begin
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.HREADY && w_word_valid) begin
          w_take       = 1'b1;
          w_hwdata_nxt = w_pack_word;
          w_state_nxt  = ST_DATA;
        end
      end
      ST_DATA: begin
        // Two-cycle ERROR: flag on the first cycle, finish the load on the second.
        if (bus.HRESP) begin
          w_error_nxt = 1'b1;
          if (bus.HREADY) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (bus.HREADY) begin
          w_addr_nxt      = r_addr + AW'(4);
          w_remaining_nxt = r_remaining - LEN_W'(1);
`ifdef ISRAM_LOADER_CHECKSUM_EN
          w_checksum_nxt  = r_checksum + r_hwdata;
`endif
          if (r_remaining == LEN_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drives the bus back to IDLE immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= 32'h0;
`ifdef ISRAM_LOADER_CHECKSUM_EN
      r_checksum  <= 32'h0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_error     <= w_error_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_s_ready   <= (w_state_nxt == ST_FILL);
      r_htrans    <= (w_state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      r_hwrite    <= (w_state_nxt == ST_ADDR);
      r_hwdata    <= w_hwdata_nxt;
`ifdef ISRAM_LOADER_CHECKSUM_EN
      r_checksum  <= w_checksum_nxt;
`endif
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
`ifdef ISRAM_LOADER_CHECKSUM_EN
  assign checksum      = r_checksum;
`endif

  assign bus.s_ready   = r_s_ready;
  assign bus.HADDR     = r_addr;
  assign bus.HTRANS    = r_htrans;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HWDATA    = r_hwdata;
  assign bus.HSIZE     = HSIZE_WORD;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_DEFAULT;
  assign bus.HMASTLOCK = 1'b0;

endmodule

// File: doc/ahb_isram_loader.md
# ahb_isram_loader

AHB-Lite initiator that loads a program image into instruction SRAM from an 8-bit valid/ready byte stream (e.g. a debug UART receiver). It packs bytes little-endian into 32-bit words and issues one single-beat word write per word on the bus matrix, with incrementing addresses. It is the master-side counterpart of the instruction SRAM AHB slave. Its completion and error status are visible to boot control.

## Interface
- AW, 16, address width; matches the SRAM slave HADDR width
- LEN_W, 14, width of word_count
- HCLK  in  1  system bus clock
- HRESETn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a load when idle
- base_addr  in  AW  first word address; latched on accepted start; bits [1:0] ignored
- word_count  in  LEN_W  number of words to write; latched on accepted start
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  byte accepted when s_valid && s_ready
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at end of load (success or error)
- error  out  1  sticky; set on HRESP error; cleared by accepted start
- HADDR  out  AW  AHB address
- HTRANS  out  2  IDLE 2'b00 or NONSEQ 2'b10 only
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant 4'b0011
- HMASTLOCK  out  1  constant 0
- HWRITE  out  1  1 during address phase, else 0
- HWDATA  out  32  write data, valid in data phase
- HREADY  in  1  bus ready
- HRESP  in  1  bus response (1 = ERROR)

## Operation
- States: IDLE, FILL, ADDR, DATA.
- IDLE: start accepted only here. Latch base_addr/word_count, clear error (and checksum). word_count==0 -> done pulse next cycle, stay IDLE. Else -> FILL, busy=1.
- FILL: s_ready=1; each handshake shifts a byte in: first byte -> [7:0] ... fourth -> [31:24]. After 4th byte -> ADDR. s_ready=0 in all other states.
- ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR=current address. Hold address/control stable while HREADY=0. On HREADY=1 -> DATA.
- DATA: HTRANS=IDLE, HWRITE=0, HWDATA=packed word held stable until HREADY=1.
  - HREADY=1, HRESP=0: address += 4 (mod 2^AW, silent wrap), remaining -= 1; remaining 0 -> IDLE + done; else -> FILL.
  - HRESP=1 (two-cycle error response): set error on first cycle; when HREADY=1 -> IDLE + done. Remaining words are abandoned. Unconsumed stream bytes stay unconsumed.
- start while busy: ignored, no effect.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0, s_ready=0, busy=0, done=0, error=0, checksum=0, state IDLE.
- All outputs are registered.
- Best-case word period: 4 FILL cycles + 1 ADDR + 1 DATA = 6 cycles. Each HREADY=0 cycle adds one cycle.
- done is asserted in the cycle after the final DATA phase completes; busy falls in the same cycle.
- Reset mid-transfer drops all state immediately. The bus sees HTRANS=IDLE from the reset assertion onward.

## Configuration
- ISRAM_LOADER_CHECKSUM_EN defined:
  - Adds output checksum [31:0]: 32-bit modulo sum of words completed with OKAY.
  - Cleared on accepted start.
  - Stable after done.
- Undefined: no checksum port and no adder.

## Structure
- Package isram_loader_pkg holds:
  - State enum.
  - HTRANS_IDLE and HTRANS_NONSEQ.
  - HSIZE_WORD, HBURST_SINGLE, HPROT_DEFAULT.
- One sub-module, byte_word_packer:
  - 8-to-32 little-endian shift, byte counter, word_valid flag, clear input.
  - Instantiated once.

## Test plan
- base_addr=0x0100, word_count=2, bytes 11 22 33 44 55 66 77 88, HREADY=1:
  - NONSEQ writes to 0x0100 (data 0x44332211) and 0x0104 (data 0x88776655).
  - done after last data phase; error=0; checksum=0xCCAA8866 when enabled.
- HREADY=0 for 3 cycles during ADDR and 2 cycles during DATA:
  - HADDR/HTRANS/HWRITE and HWDATA held stable throughout.
  - Word period = 11 cycles.
- Error on first word: HRESP=1/HREADY=0 then HRESP=1/HREADY=1, word_count=4:
  - error=1, done pulses, busy=0.
  - No further NONSEQ; s_ready stays 0.
- Wrap and zero count:
  - word_count=0 -> done pulse next cycle, zero bus transfers.
  - base_addr=0xFFFC, word_count=2 -> writes to 0xFFFC then 0x0000.
- Stalls, start while busy, reset mid-load:
  - s_valid gaps mid-word: still one transfer per 4 bytes.
  - start pulsed while busy: ignored, latched values unchanged.
  - HRESETn low during DATA: all outputs return to reset values asynchronously.
